// File: rtl/eeprom_pkg.sv
// Shared definitions for the EEPROM boot path.
// Holds the boot sequencer state encoding, error codes, boot header field
// offsets, the default header magic byte and the running checksum helper.
package eeprom_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_HDR_REQ   = 4'd1,
    ST_HDR_WAIT  = 4'd2,
    ST_HDR_CHECK = 4'd3,
    ST_PG_REQ    = 4'd4,
    ST_PG_WAIT   = 4'd5,
    ST_CHECK     = 4'd6,
    ST_DONE      = 4'd7,
    ST_FAIL      = 4'd8
  } boot_state_e;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_HDR  = 2'd1,
    ERR_CSUM = 2'd2,
    ERR_TMO  = 2'd3
  } boot_err_e;

  // Header layout in page 0: magic, page count, checksum, reserved (byte 3,
  // read but not stored).
  localparam logic [7:0] HDR_OFF_MAGIC  = 8'd0;
  localparam logic [7:0] HDR_OFF_NPAGES = 8'd1;
  localparam logic [7:0] HDR_OFF_CSUM   = 8'd2;
  localparam logic [7:0] HDR_BYTES      = 8'd4;

  localparam logic [7:0] MAGIC_DEFAULT = 8'hE0;

  // 8-bit additive checksum step (wraps modulo 256).
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/eeprom_boot_loader.sv
// eeprom_boot_loader: copies a boot image from an I2C EEPROM into on-chip
// memory after reset by sequencing a read_eeprom block.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   start             begin a boot load (sampled only when idle)
//   busy              load in progress
//   done              image loaded and checksum good (level, until next start)
//   error             0 none, 1 bad header, 2 checksum, 3 timeout/short read
//   ee_slave_addr     EEPROM I2C address (constant)
//   ee_page_addr      page index of the current read request
//   ee_nbytes         byte count of the current read request
//   ee_start          one-cycle read request pulse
//   ee_data           byte from the reader
//   ee_byte_ready     one-cycle strobe qualifying ee_data
//   ee_busy           reader busy
//   mem_we            one-cycle memory word write strobe
//   mem_addr          memory word address
//   mem_wdata         {even byte, odd byte} of the payload pair
module eeprom_boot_loader
  import eeprom_pkg::*;
#(
  parameter int          PAGE_BYTES = 32,
  parameter logic [6:0]  SLAVE_ADDR = 7'h50,
  parameter logic [7:0]  MAGIC      = MAGIC_DEFAULT,
  parameter logic [15:0] LOAD_BASE  = 16'h0000,
  parameter int          TIMEOUT    = 1 << 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [1:0]  error,
  output logic [6:0]  ee_slave_addr,
  output logic [15:0] ee_page_addr,
  output logic [7:0]  ee_nbytes,
  output logic        ee_start,
  input  logic [7:0]  ee_data,
  input  logic        ee_byte_ready,
  input  logic        ee_busy,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata
);

  localparam int              WD_W         = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LIMIT     = WD_W'(TIMEOUT);
  localparam logic [WD_W-1:0] WD_ONE       = WD_W'(1);
  localparam logic [7:0]      PAGE_BYTES_B = 8'(PAGE_BYTES);

  boot_state_e     state_r, state_nxt_s;
  boot_err_e       fail_code_r, fail_code_s;
  logic [7:0]      page_r;
  logic [7:0]      npages_r;
  logic [7:0]      magic_r;
  logic [7:0]      csum_r;
  logic [7:0]      sum_r;
  logic [7:0]      hold_r;
  logic [7:0]      byte_idx_r;
  logic            busy_seen_r;
  logic [WD_W-1:0] wd_r;
  logic            wd_expired_s;
  logic            read_end_s;

  // Next-state decode and failure cause selection.
  always_comb begin
    state_nxt_s  = state_r;
    fail_code_s  = fail_code_r;
    wd_expired_s = (wd_r >= WD_LIMIT);
    // A read is over only once the reader has been seen busy and is idle again;
    // this skips the cycle(s) before ee_busy rises after ee_start.
    read_end_s   = busy_seen_r && !ee_busy;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_HDR_REQ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_HDR_REQ: begin
        if (!ee_busy) begin
          state_nxt_s = ST_HDR_WAIT;
        end else begin
          state_nxt_s = ST_HDR_REQ;
        end
      end
      ST_HDR_WAIT: begin
        if (wd_expired_s) begin
          state_nxt_s = ST_FAIL;
          fail_code_s = ERR_TMO;
        end else if (read_end_s) begin
          state_nxt_s = ST_HDR_CHECK;
        end else begin
          state_nxt_s = ST_HDR_WAIT;
        end
      end
      ST_HDR_CHECK: begin
        if ((magic_r != MAGIC) || (npages_r == 8'd0)) begin
          state_nxt_s = ST_FAIL;
          fail_code_s = ERR_HDR;
        end else begin
          state_nxt_s = ST_PG_REQ;
        end
      end
      ST_PG_REQ: begin
        state_nxt_s = ST_PG_WAIT;
      end
      ST_PG_WAIT: begin
        if (wd_expired_s) begin
          state_nxt_s = ST_FAIL;
          fail_code_s = ERR_TMO;
        end else if (read_end_s) begin
          if (byte_idx_r != PAGE_BYTES_B) begin
            state_nxt_s = ST_FAIL;
            fail_code_s = ERR_TMO;
          end else if (page_r == npages_r) begin
            state_nxt_s = ST_CHECK;
          end else begin
            state_nxt_s = ST_PG_REQ;
          end
        end else begin
          state_nxt_s = ST_PG_WAIT;
        end
      end
      ST_CHECK: begin
        if (sum_r == csum_r) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_FAIL;
          fail_code_s = ERR_CSUM;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      ST_FAIL: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      fail_code_r   <= ERR_NONE;
      page_r        <= 8'd0;
      npages_r      <= 8'd0;
      magic_r       <= 8'd0;
      csum_r        <= 8'd0;
      sum_r         <= 8'd0;
      hold_r        <= 8'd0;
      byte_idx_r    <= 8'd0;
      busy_seen_r   <= 1'b0;
      wd_r          <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 2'd0;
      ee_slave_addr <= SLAVE_ADDR;
      ee_page_addr  <= 16'd0;
      ee_nbytes     <= 8'd0;
      ee_start      <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= 16'd0;
      mem_wdata     <= 16'd0;
    end else begin
      state_r       <= state_nxt_s;
      fail_code_r   <= fail_code_s;
      ee_slave_addr <= SLAVE_ADDR;
      ee_start      <= 1'b0;
      mem_we        <= 1'b0;
      // Address advances after each word write (wraps at 16 bits).
      if (mem_we) begin
        mem_addr <= mem_addr + 16'd1;
      end
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            busy     <= 1'b1;
            done     <= 1'b0;
            error    <= ERR_NONE;
            page_r   <= 8'd0;
            mem_addr <= LOAD_BASE;
            sum_r    <= 8'd0;
          end
        end
        ST_HDR_REQ: begin
          if (!ee_busy) begin
            ee_start     <= 1'b1;
            ee_page_addr <= 16'd0;
            ee_nbytes    <= HDR_BYTES;
            wd_r         <= '0;
            busy_seen_r  <= 1'b0;
            byte_idx_r   <= 8'd0;
          end
        end
        ST_HDR_WAIT: begin
          wd_r <= wd_r + WD_ONE;
          if (ee_busy) begin
            busy_seen_r <= 1'b1;
          end
          if (ee_byte_ready) begin
            byte_idx_r <= byte_idx_r + 8'd1;
            case (byte_idx_r)
              HDR_OFF_MAGIC:  magic_r  <= ee_data;
              HDR_OFF_NPAGES: npages_r <= ee_data;
              HDR_OFF_CSUM:   csum_r   <= ee_data;
              default: ;
            endcase
          end
        end
        ST_HDR_CHECK: begin
          page_r <= 8'd1;
        end
        ST_PG_REQ: begin
          ee_start     <= 1'b1;
          ee_page_addr <= {8'h00, page_r};
          ee_nbytes    <= PAGE_BYTES_B;
          wd_r         <= '0;
          busy_seen_r  <= 1'b0;
          byte_idx_r   <= 8'd0;
        end
        ST_PG_WAIT: begin
          wd_r <= wd_r + WD_ONE;
          if (ee_busy) begin
            busy_seen_r <= 1'b1;
          end
          if (ee_byte_ready) begin
            sum_r      <= csum_add(sum_r, ee_data);
            byte_idx_r <= byte_idx_r + 8'd1;
            // Even byte is held; odd byte completes a big-endian word.
            if (!byte_idx_r[0]) begin
              hold_r <= ee_data;
            end else begin
              mem_wdata <= {hold_r, ee_data};
              mem_we    <= 1'b1;
            end
          end
          if (state_nxt_s == ST_PG_REQ) begin
            page_r <= page_r + 8'd1;
          end
        end
        ST_CHECK: begin
          busy <= 1'b1;
        end
        ST_DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        ST_FAIL: begin
          error <= fail_code_r;
          busy  <= 1'b0;
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eeprom_boot_loader.sv
// Self-checking bench for eeprom_boot_loader with a behavioural EEPROM
// reader and an image-level reference model.
module tb_eeprom_boot_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy, done;
  logic [1:0]  error;
  logic [6:0]  ee_slave_addr;
  logic [15:0] ee_page_addr;
  logic [7:0]  ee_nbytes;
  logic        ee_start;
  logic [7:0]  ee_data;
  logic        ee_byte_ready;
  logic        ee_busy;
  logic        mem_we;
  logic [15:0] mem_addr, mem_wdata;

  eeprom_boot_loader #(
    .PAGE_BYTES(32), .SLAVE_ADDR(7'h50), .MAGIC(8'hE0),
    .LOAD_BASE(16'h0000), .TIMEOUT(1000)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .error(error), .ee_slave_addr(ee_slave_addr), .ee_page_addr(ee_page_addr),
    .ee_nbytes(ee_nbytes), .ee_start(ee_start), .ee_data(ee_data),
    .ee_byte_ready(ee_byte_ready), .ee_busy(ee_busy), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // EEPROM contents: page 0 = header, pages 1..3 = payload.
  logic [7:0]  ee_mem [0:3][0:31];
  int          short_pg = 0;   // payload page delivered with one byte missing (0 = none)
  int          hang_pg  = 0;   // payload page whose read never finishes (0 = none)
  int          req_cnt  = 0;
  int          tmo_req_cyc = 0;
  logic [31:0] obs_q[$];

  // Reference expectations.
  logic [31:0] exp_q[$];
  int          exp_err;
  int          exp_reqs;

  // Behavioural reader + write monitor, stepped on the falling edge.
  initial begin
    bit   rd_active, rd_hang, prev_start;
    int   rd_pg, rd_n, rd_idx, rd_gap, prev_pg;
    rd_active = 0; rd_hang = 0; prev_start = 0; prev_pg = 0;
    rd_pg = 0; rd_n = 0; rd_idx = 0; rd_gap = 0;
    ee_busy = 1'b0; ee_data = 8'h00; ee_byte_ready = 1'b0;
    forever begin
      @(negedge clk);
      ee_byte_ready = 1'b0;
      if (!reset && mem_we) obs_q.push_back({mem_addr, mem_wdata});
      if (reset) begin
        rd_active = 0;
        ee_busy   = 1'b0;
      end else if (ee_start) begin
        check_value("ee_start_width", {31'd0, prev_start}, 32'd0);
        check_value("slave_addr", {25'd0, ee_slave_addr}, 32'h50);
        if (ee_page_addr == 16'd0) begin
          check_value("hdr_nbytes", {24'd0, ee_nbytes}, 32'd4);
        end else begin
          check_value("pg_nbytes", {24'd0, ee_nbytes}, 32'd32);
          check_value("pg_seq", {16'd0, ee_page_addr}, prev_pg + 1);
        end
        prev_pg = ee_page_addr;
        req_cnt++;
        rd_pg   = ee_page_addr & 3;
        rd_n    = (short_pg != 0 && ee_page_addr == short_pg) ? ee_nbytes - 1 : ee_nbytes;
        rd_hang = (hang_pg != 0 && ee_page_addr == hang_pg);
        if (rd_hang) tmo_req_cyc = cyc;
        rd_idx = 0;
        rd_gap = $urandom_range(0, 2);
        rd_active = 1;
        ee_busy = 1'b1;
      end else if (rd_active) begin
        if (rd_idx < rd_n) begin
          if (rd_gap > 0) begin
            rd_gap--;
          end else begin
            ee_data       = ee_mem[rd_pg][rd_idx & 31];
            ee_byte_ready = 1'b1;
            rd_idx++;
            rd_gap = $urandom_range(0, 2);
          end
        end else if (!rd_hang) begin
          ee_busy   = 1'b0;
          rd_active = 0;
        end
      end
      prev_start = ee_start;
    end
  end

  // Image-level model: what a boot of the current EEPROM contents must do.
  task automatic build_expect();
    logic [7:0]  sum;
    logic [15:0] addr;
    int          sent;
    exp_q.delete();
    sum = 8'h00;
    addr = 16'h0000;
    exp_err = 0;
    exp_reqs = 1;
    if (ee_mem[0][0] != 8'hE0 || ee_mem[0][1] == 8'h00) begin
      exp_err = 1;
    end else begin
      for (int p = 1; p <= int'(ee_mem[0][1]); p++) begin
        sent = (p == short_pg) ? 31 : 32;
        for (int i = 0; i < sent; i++) sum = sum + ee_mem[p][i];
        for (int i = 0; i + 1 < sent; i += 2) begin
          exp_q.push_back({addr, ee_mem[p][i], ee_mem[p][i+1]});
          addr = addr + 16'd1;
        end
        exp_reqs = p + 1;
        if (p == short_pg || p == hang_pg) begin
          exp_err = 3;
          break;
        end
      end
      if (exp_err == 0) exp_err = (sum == ee_mem[0][2]) ? 0 : 2;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic fill_image(input int np, input bit counting, input bit good_sum);
    logic [7:0] s;
    s = 8'h00;
    for (int p = 1; p < 4; p++)
      for (int i = 0; i < 32; i++) begin
        ee_mem[p][i] = counting ? 8'((p - 1) * 32 + i) : 8'($urandom_range(0, 255));
        if (p <= np) s = s + ee_mem[p][i];
      end
    ee_mem[0][0] = 8'hE0;
    ee_mem[0][1] = 8'(np);
    ee_mem[0][2] = good_sum ? s : s + 8'd1;
    ee_mem[0][3] = 8'($urandom_range(0, 255));
  endtask

  // One boot: pulse start, wait (bounded) for completion, compare with model.
  task automatic run_boot(input string tag, input bit spam, output int base, output int end_cyc);
    int rb, nobs;
    bit fin;
    build_expect();
    base = obs_q.size();
    rb   = req_cnt;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_value({tag, ":busy_rise"}, {31'd0, busy}, 32'd1);
    check_value({tag, ":done_clr"}, {31'd0, done}, 32'd0);
    check_value({tag, ":err_clr"}, {30'd0, error}, 32'd0);
    fin = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      start = spam && busy && (k == 20 || k == 70);
      if (!busy) begin
        fin = 1;
        break;
      end
    end
    start = 1'b0;
    end_cyc = cyc;
    check_value({tag, ":finished"}, {31'd0, fin}, 32'd1);
    check_value({tag, ":error"}, {30'd0, error}, exp_err);
    check_value({tag, ":done"}, {31'd0, done}, (exp_err == 0) ? 32'd1 : 32'd0);
    check_value({tag, ":reqs"}, req_cnt - rb, exp_reqs);
    nobs = obs_q.size() - base;
    check_value({tag, ":nwrites"}, nobs, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < nobs; i++)
      check_value({tag, ":write"}, obs_q[base + i], exp_q[i]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_value({tag, ":busy"}, {31'd0, busy}, 32'd0);
    check_value({tag, ":done"}, {31'd0, done}, 32'd0);
    check_value({tag, ":error"}, {30'd0, error}, 32'd0);
    check_value({tag, ":slave"}, {25'd0, ee_slave_addr}, 32'h50);
    check_value({tag, ":page"}, {16'd0, ee_page_addr}, 32'd0);
    check_value({tag, ":nbytes"}, {24'd0, ee_nbytes}, 32'd0);
    check_value({tag, ":ee_start"}, {31'd0, ee_start}, 32'd0);
    check_value({tag, ":mem"}, {15'd0, mem_we, mem_addr}, 32'd0);
    check_value({tag, ":wdata"}, {16'd0, mem_wdata}, 32'd0);
  endtask

  initial begin
    int base, endc, wcnt;
    reset = 1'b1;
    start = 1'b0;
    fill_image(2, 1'b1, 1'b1);
    apply_reset();
    check_reset_outputs("rst");

    // Directed image: two pages of 00..3F, correct checksum.
    run_boot("dir", 1'b0, base, endc);
    check_value("dir:err0", {30'd0, error}, 32'd0);
    check_value("dir:first", obs_q[base], {16'h0000, 16'h0001});
    check_value("dir:last", obs_q[base + 31], {16'd31, 16'h3E3F});

    // Second start after DONE repeats the load identically.
    run_boot("again", 1'b0, base, endc);

    // Bad headers.
    apply_reset();
    ee_mem[0][0] = 8'hA5;
    run_boot("magic", 1'b0, base, endc);
    check_value("magic:err1", {30'd0, error}, 32'd1);
    fill_image(2, 1'b1, 1'b1);
    ee_mem[0][1] = 8'h00;
    run_boot("np0", 1'b0, base, endc);

    // Checksum off by one.
    fill_image(3, 1'b0, 1'b0);
    run_boot("csum", 1'b0, base, endc);
    check_value("csum:err2", {30'd0, error}, 32'd2);

    // Reader never finishes page 1.
    fill_image(2, 1'b0, 1'b1);
    hang_pg = 1;
    run_boot("hang", 1'b0, base, endc);
    check_value("hang:latency_ok", {31'd0, (endc - tmo_req_cyc >= 1000) && (endc - tmo_req_cyc <= 1010)}, 32'd1);
    hang_pg = 0;
    apply_reset();

    // Short second page.
    short_pg = 2;
    run_boot("short", 1'b0, base, endc);
    short_pg = 0;
    apply_reset();

    // Reset in the middle of a page read, then a clean load.
    fill_image(2, 1'b0, 1'b1);
    base = obs_q.size();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 3000 && obs_q.size() < base + 5; k++) @(negedge clk);
    check_value("midrst:reached", {31'd0, obs_q.size() >= base + 5}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    wcnt = obs_q.size();
    @(negedge clk);
    reset = 1'b0;
    check_value("midrst:no_we", obs_q.size(), wcnt);
    run_boot("postrst", 1'b0, base, endc);

    // Start pulses while busy are ignored.
    run_boot("spam", 1'b1, base, endc);

    // Randomised images.
    for (int it = 0; it < 4; it++) begin
      fill_image($urandom_range(1, 3), 1'b0, 1'($urandom_range(0, 1)));
      run_boot("rand", 1'b0, base, endc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "simulation time limit");
  end

endmodule
